oled_frame_sequencer: RTL and testbench

//  Sequencer for the display SPI master: pulses panel reset, plays a fixed SSD1306 init

---
 rtl/oled_frame_sequencer_if.sv | 10 +
 rtl/oled_frame_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_oled_frame_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_frame_sequencer_if.sv
// Byte-level handshake between the OLED frame sequencer and the display SPI master.
interface oled_frame_sequencer_if;
    logic [7:0] spi_data;
    logic       spi_dc;
    logic       spi_send;
    logic       spi_send_done;

    modport master (output spi_data, output spi_dc, output spi_send, input spi_send_done);
    modport slave  (input spi_data, input spi_dc, input spi_send, output spi_send_done);
endinterface

// File: rtl/oled_frame_sequencer.sv
// SSD1306 panel reset, init-ROM playback and page-by-page framebuffer streaming.
// Optional periodic self-refresh is enabled by defining OLED_AUTO_REFRESH_EN.
module oled_frame_sequencer #(
    parameter int RST_CYCLES     = 100000,
    parameter int N_PAGES        = 8,
    parameter int N_COLS         = 128,
    parameter int REFRESH_CYCLES = 5000000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          refresh_req,
    output logic                          busy,
    output logic                          init_done,
    output logic                          frame_done,
    output logic [9:0]                    fb_addr,
    input  logic [7:0]                    fb_rdata,
    output logic                          oled_res_n,
    oled_frame_sequencer_if.master        spi
);
    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [6:0]       COL_LAST  = 7'(N_COLS - 1);
    localparam logic [2:0]       PAGE_LAST = 3'(N_PAGES - 1);
    localparam logic [4:0]       ROM_LAST  = 5'd24;

    typedef enum logic [2:0] {
        S_PANEL_RST, S_RST_WAIT, S_INIT, S_IDLE, S_PAGE_CMD, S_FETCH, S_PAGE_DATA
    } state_t;

    state_t           state_q;
    logic [RST_W-1:0] rst_cnt_q;
    logic [4:0]       rom_idx_q;
    logic [1:0]       cmd_idx_q;
    logic [2:0]       page_q;
    logic [6:0]       col_q;
    logic             drain_q;
    logic             fetch_wait_q;
    logic             pending_q;
    logic             busy_q, init_done_q, frame_done_q, oled_res_n_q;
    logic [9:0]       fb_addr_q;
    logic [7:0]       spi_data_q;
    logic             spi_dc_q, spi_send_q;
    logic             auto_tick;
    logic             byte_ack;
    logic [2:0]       page_inc;

    function automatic logic [7:0] init_rom(input logic [4:0] idx);
        case (idx)
            5'd0:  return 8'hAE;  5'd1:  return 8'hD5;  5'd2:  return 8'h80;
            5'd3:  return 8'hA8;  5'd4:  return 8'h3F;  5'd5:  return 8'hD3;
            5'd6:  return 8'h00;  5'd7:  return 8'h40;  5'd8:  return 8'h8D;
            5'd9:  return 8'h14;  5'd10: return 8'h20;  5'd11: return 8'h02;
            5'd12: return 8'hA1;  5'd13: return 8'hC8;  5'd14: return 8'hDA;
            5'd15: return 8'h12;  5'd16: return 8'h81;  5'd17: return 8'hCF;
            5'd18: return 8'hD9;  5'd19: return 8'hF1;  5'd20: return 8'hDB;
            5'd21: return 8'h40;  5'd22: return 8'hA4;  5'd23: return 8'hA6;
            default: return 8'hAF;
        endcase
    endfunction

    function automatic logic [9:0] fb_index(input logic [2:0] p, input logic [6:0] c);
        return 10'(int'(p) * N_COLS + int'(c));
    endfunction

    // A byte is acknowledged once done has been seen high and then low again.
    assign byte_ack = drain_q && !spi.spi_send_done;
    assign page_inc = page_q + 3'd1;

`ifdef OLED_AUTO_REFRESH_EN
    localparam int RF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_CYCLES - 1);
    logic [RF_W-1:0] refresh_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            refresh_cnt_q <= '0;
        end else if (init_done_q) begin
            refresh_cnt_q <= (refresh_cnt_q == RF_LAST) ? '0 : refresh_cnt_q + 1'b1;
        end
    end
    assign auto_tick = init_done_q && (refresh_cnt_q == RF_LAST);
`else
    assign auto_tick = (REFRESH_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_PANEL_RST;
            rst_cnt_q    <= '0;
            rom_idx_q    <= '0;
            cmd_idx_q    <= '0;
            page_q       <= '0;
            col_q        <= '0;
            drain_q      <= 1'b0;
            fetch_wait_q <= 1'b0;
            pending_q    <= 1'b0;
            busy_q       <= 1'b1;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            oled_res_n_q <= 1'b0;
            fb_addr_q    <= '0;
            spi_data_q   <= 8'h00;
            spi_dc_q     <= 1'b0;
            spi_send_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (state_q == S_INIT || state_q == S_PAGE_CMD || state_q == S_PAGE_DATA) begin
                if (!drain_q && spi.spi_send_done) begin
                    spi_send_q <= 1'b0;
                    drain_q    <= 1'b1;
                end else if (byte_ack) begin
                    drain_q <= 1'b0;
                end
            end
            case (state_q)
                S_PANEL_RST: begin
                    if (rst_cnt_q == RST_LAST) begin
                        rst_cnt_q    <= '0;
                        oled_res_n_q <= 1'b1;
                        state_q      <= S_RST_WAIT;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                S_RST_WAIT: begin
                    if (rst_cnt_q == RST_LAST) begin
                        rst_cnt_q  <= '0;
                        rom_idx_q  <= '0;
                        spi_data_q <= init_rom(5'd0);
                        spi_dc_q   <= 1'b0;
                        spi_send_q <= 1'b1;
                        state_q    <= S_INIT;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                S_INIT: begin
                    if (byte_ack) begin
                        if (rom_idx_q == ROM_LAST) begin
                            init_done_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            rom_idx_q  <= rom_idx_q + 5'd1;
                            spi_data_q <= init_rom(rom_idx_q + 5'd1);
                            spi_send_q <= 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (pending_q) begin
                        pending_q  <= 1'b0;
                        page_q     <= '0;
                        cmd_idx_q  <= '0;
                        spi_data_q <= 8'hB0;
                        spi_dc_q   <= 1'b0;
                        spi_send_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_PAGE_CMD;
                    end
                end
                S_PAGE_CMD: begin
                    if (byte_ack) begin
                        if (cmd_idx_q == 2'd0) begin
                            spi_data_q <= 8'h00;
                            spi_send_q <= 1'b1;
                            cmd_idx_q  <= 2'd1;
                        end else if (cmd_idx_q == 2'd1) begin
                            spi_data_q <= 8'h10;
                            spi_send_q <= 1'b1;
                            cmd_idx_q  <= 2'd2;
                        end else begin
                            col_q        <= '0;
                            fb_addr_q    <= fb_index(page_q, 7'd0);
                            fetch_wait_q <= 1'b0;
                            state_q      <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    // First cycle presents the address, second cycle captures the read data.
                    if (!fetch_wait_q) begin
                        fetch_wait_q <= 1'b1;
                    end else begin
                        fetch_wait_q <= 1'b0;
                        spi_data_q   <= fb_rdata;
                        spi_dc_q     <= 1'b1;
                        spi_send_q   <= 1'b1;
                        state_q      <= S_PAGE_DATA;
                    end
                end
                S_PAGE_DATA: begin
                    if (byte_ack) begin
                        if (col_q == COL_LAST) begin
                            if (page_q == PAGE_LAST) begin
                                frame_done_q <= 1'b1;
                                busy_q       <= 1'b0;
                                state_q      <= S_IDLE;
                            end else begin
                                page_q     <= page_inc;
                                cmd_idx_q  <= '0;
                                spi_data_q <= {4'hB, 1'b0, page_inc};
                                spi_dc_q   <= 1'b0;
                                spi_send_q <= 1'b1;
                                state_q    <= S_PAGE_CMD;
                            end
                        end else begin
                            col_q        <= col_q + 7'd1;
                            fb_addr_q    <= fb_index(page_q, col_q + 7'd1);
                            fetch_wait_q <= 1'b0;
                            state_q      <= S_FETCH;
                        end
                    end
                end
                default: state_q <= S_PANEL_RST;
            endcase
            // Late assignment wins, so a request coinciding with consumption stays pending.
            if (refresh_req || auto_tick) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign busy         = busy_q;
    assign init_done    = init_done_q;
    assign frame_done   = frame_done_q;
    assign fb_addr      = fb_addr_q;
    assign oled_res_n   = oled_res_n_q;
    assign spi.spi_data = spi_data_q;
    assign spi.spi_dc   = spi_dc_q;
    assign spi.spi_send = spi_send_q;
endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Directed/randomized bench for oled_frame_sequencer with an SPI byte-sink model and frame reference.
module tb_oled_frame_sequencer;
    localparam int RST_C = 4;
    localparam int NP    = 2;
    localparam int NC    = 4;
    localparam int RF    = 200;
    localparam int LAT   = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       refresh_req = 1'b0;
    logic       busy, init_done, frame_done, oled_res_n;
    logic [9:0] fb_addr;
    logic [7:0] fb_rdata;

    oled_frame_sequencer_if spi_if ();

    oled_frame_sequencer #(
        .RST_CYCLES(RST_C), .N_PAGES(NP), .N_COLS(NC), .REFRESH_CYCLES(RF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .refresh_req(refresh_req), .busy(busy),
        .init_done(init_done), .frame_done(frame_done), .fb_addr(fb_addr),
        .fb_rdata(fb_rdata), .oled_res_n(oled_res_n), .spi(spi_if)
    );

    always #5 clk = ~clk;

    logic [7:0] fb_mem [0:1023];
    always @(posedge clk) fb_rdata <= fb_mem[fb_addr];

    logic [7:0] rom_ref [0:24] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                   8'h8D, 8'h14, 8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                                   8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
                                   8'hAF};

    int checks = 0;
    int passes = 0;
    int stab_err = 0;
    int fd_count = 0;
    bit hold_fixed = 1'b0;
    logic [8:0] got_q [$];
    logic [8:0] exp_q [$];

    // SPI master model: accepts a byte, raises done after LAT cycles, holds it 1..10 cycles.
    int         m_state = 0;
    int         m_cnt = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_dc = 1'b0;
    initial begin
        spi_if.spi_send_done = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) fd_count++;
            if (!reset_n) begin
                m_state = 0;
                spi_if.spi_send_done = 1'b0;
            end else begin
                case (m_state)
                    0: if (spi_if.spi_send === 1'b1) begin
                        m_data = spi_if.spi_data; m_dc = spi_if.spi_dc;
                        m_cnt = LAT; m_state = 1;
                    end
                    1: begin
                        if (spi_if.spi_send !== 1'b1 || spi_if.spi_data !== m_data || spi_if.spi_dc !== m_dc)
                            stab_err++;
                        m_cnt--;
                        if (m_cnt == 0) begin
                            spi_if.spi_send_done = 1'b1;
                            got_q.push_back({m_dc, m_data});
                            m_cnt = hold_fixed ? 10 : int'($urandom_range(1, 10));
                            m_state = 2;
                        end
                    end
                    default: begin
                        if (spi_if.spi_send !== 1'b0 || spi_if.spi_data !== m_data || spi_if.spi_dc !== m_dc)
                            stab_err++;
                        m_cnt--;
                        if (m_cnt == 0) begin
                            spi_if.spi_send_done = 1'b0;
                            m_state = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_refresh();
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
    endtask

    function automatic void exp_init();
        for (int i = 0; i < 25; i++) exp_q.push_back({1'b0, rom_ref[i]});
    endfunction

    function automatic void exp_frame();
        for (int p = 0; p < NP; p++) begin
            exp_q.push_back({1'b0, 8'hB0 | 8'(p)});
            exp_q.push_back(9'h000);
            exp_q.push_back(9'h010);
            for (int c = 0; c < NC; c++) exp_q.push_back({1'b1, fb_mem[p * NC + c]});
        end
    endfunction

    function automatic void fill_fb_random();
        for (int i = 0; i < 1024; i++) fb_mem[i] = 8'($urandom);
    endfunction

    task automatic compare_bytes(input string tag, input bit exact);
        int n;
        if (exact) check({tag, "_count"}, got_q.size(), exp_q.size());
        else       check({tag, "_count"}, 32'(got_q.size() >= exp_q.size()), 1);
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic wait_init(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (init_done === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check(tag, ok, 1);
    endtask

    task automatic wait_frames(input string tag, input int base);
        bit ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (fd_count > base) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check(tag, ok, 1);
    endtask

    initial begin
        int n_low, n_high, fd0;
        bit ok;
        for (int i = 0; i < 1024; i++) fb_mem[i] = 8'(i);

        tick(5);
        check("rst_res_n", oled_res_n, 0);
        check("rst_send", spi_if.spi_send, 0);
        check("rst_data", spi_if.spi_data, 0);
        check("rst_dc", spi_if.spi_dc, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_busy", busy, 1);
        check("rst_init_done", init_done, 0);
        check("rst_frame_done", frame_done, 0);

        reset_n = 1'b1;
        n_low = 0;
        while (oled_res_n === 1'b0 && n_low < 100) begin n_low++; @(negedge clk); end
        check("res_n_low_cycles", n_low, RST_C);
        n_high = 0;
        while (oled_res_n === 1'b1 && spi_if.spi_send === 1'b0 && n_high < 100) begin n_high++; @(negedge clk); end
        check("res_n_high_cycles", n_high, RST_C);
        check("res_n_stays_high", oled_res_n, 1);

        exp_init();
        wait_init("init_timeout");
        tick(2);
        check("init_busy", busy, 0);
        compare_bytes("init", 1'b1);

`ifdef OLED_AUTO_REFRESH_EN
        fill_fb_random();
        got_q.delete(); exp_q.delete(); exp_frame();
        fd0 = fd_count;
        wait_frames("auto_frame_timeout", fd0);
        compare_bytes("auto_frame", 1'b0);
`else
        got_q.delete(); exp_q.delete(); exp_frame();
        fd0 = fd_count;
        pulse_refresh();
        wait_frames("frame1_timeout", fd0);
        tick(5);
        check("frame1_done_pulses", fd_count - fd0, 1);
        check("frame1_busy", busy, 0);
        compare_bytes("frame1", 1'b1);

        fill_fb_random();
        hold_fixed = 1'b1;
        got_q.delete(); exp_q.delete(); exp_frame();
        fd0 = fd_count;
        pulse_refresh();
        wait_frames("hold10_timeout", fd0);
        tick(5);
        hold_fixed = 1'b0;
        compare_bytes("hold10", 1'b1);

        fill_fb_random();
        got_q.delete(); exp_q.delete(); exp_frame(); exp_frame();
        fd0 = fd_count;
        pulse_refresh();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (busy === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("coalesce_busy", ok, 1);
        for (int k = 0; k < 3; k++) begin
            tick(int'($urandom_range(1, 30)));
            pulse_refresh();
        end
        tick(3000);
        check("coalesce_frames", fd_count - fd0, 2);
        check("coalesce_busy_end", busy, 0);
        compare_bytes("coalesce", 1'b1);

        fill_fb_random();
        reset_n = 1'b0;
        tick(2);
        got_q.delete(); exp_q.delete(); exp_init(); exp_frame();
        reset_n = 1'b1;
        fd0 = fd_count;
        pulse_refresh();
        wait_frames("req_in_rst_timeout", fd0);
        tick(5);
        compare_bytes("req_in_rst", 1'b1);

        pulse_refresh();
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (spi_if.spi_send === 1'b1 && spi_if.spi_dc === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("mid_data_reached", ok, 1);
        reset_n = 1'b0;
        tick(1);
        check("midrst_send", spi_if.spi_send, 0);
        check("midrst_res_n", oled_res_n, 0);
        check("midrst_busy", busy, 1);
        check("midrst_init_done", init_done, 0);
        tick(2);
        got_q.delete(); exp_q.delete(); exp_init();
        reset_n = 1'b1;
        wait_init("replay_timeout");
        tick(20);
        check("replay_busy", busy, 0);
        compare_bytes("replay", 1'b1);
`endif
        check("data_stability_errors", stab_err, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
